// File: rtl/sync_pkg.sv
// Shared types and Gray helpers for the FIFO pointer synchronisers.
// Gray check logic is compiled in only when SYNC_GRAY_CHECK_EN is defined.
package sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int GRAY_W_MAX      = 32;

  typedef enum logic {
    WARMUP = 1'b0,
    READY  = 1'b1
  } sync_state_t;

  // Callers zero-extend to GRAY_W_MAX; w is the meaningful width.
  function automatic logic [GRAY_W_MAX-1:0] gray2bin(
    input logic [GRAY_W_MAX-1:0] g,
    input int                    w
  );
    logic [GRAY_W_MAX-1:0] b;
    b = g;
    for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    for (int i = 0; i < GRAY_W_MAX; i++) begin
      if (i >= w) b[i] = 1'b0;
    end
    return b;
  endfunction

  function automatic logic [GRAY_W_MAX-1:0] bin2gray(
    input logic [GRAY_W_MAX-1:0] b,
    input int                    w
  );
    logic [GRAY_W_MAX-1:0] g;
    g = b ^ (b >> 1);
    for (int i = 0; i < GRAY_W_MAX; i++) begin
      if (i >= w) g[i] = 1'b0;
    end
    return g;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Generic multi-flop synchroniser chain, async active-high reset.
// Pure flops: no logic between stages.
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES < 1) begin : g_bad_stages
    $error("sync_chain: STAGES must be >= 1");
  end

  logic [WIDTH-1:0] ff [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        ff[i] <= '0;
      end
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/sync_r2w_gray.sv
// Read-to-write Gray pointer synchroniser with level/full flags.
// Define SYNC_GRAY_CHECK_EN to build the sticky gray_err checker.
module sync_r2w_gray
  import sync_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_LVL   = DEPTH - 2
) (
  input  logic                   w_clk,
  input  logic                   rst,
  input  logic [$clog2(DEPTH):0] rptr_gray,
  input  logic [$clog2(DEPTH):0] wptr_bin,
  output logic [$clog2(DEPTH):0] rptr_bin_sync,
  output logic [$clog2(DEPTH):0] wlevel,
  output logic                   wfull,
  output logic                   walmost_full,
  output logic                   sync_ready,
  output logic                   gray_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PW     = ADDR_W + 1;
  localparam int CW     = $clog2(SYNC_STAGES + 2);

  if (SYNC_STAGES < SYNC_STAGES_MIN ||
      SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_r2w_gray: SYNC_STAGES out of range");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_r2w_gray: DEPTH must be a power of two >= 2");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
    $error("sync_r2w_gray: AFULL_LVL out of range");
  end
  if (PW > GRAY_W_MAX) begin : g_bad_width
    $error("sync_r2w_gray: pointer too wide");
  end

  logic [PW-1:0] sync_out;
  logic [PW-1:0] rptr_bin_d;
  logic [PW-1:0] rptr_bin_q;
  sync_state_t   state;
  sync_state_t   state_d;
  logic [CW-1:0] count;
  logic [CW-1:0] count_d;

  sync_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_chain (
    .clk (w_clk),
    .rst (rst),
    .d   (rptr_gray),
    .q   (sync_out)
  );

  assign rptr_bin_d =
    PW'(gray2bin(GRAY_W_MAX'(sync_out), PW));

  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      rptr_bin_q <= '0;
    end else begin
      rptr_bin_q <= rptr_bin_d;
    end
  end

  // Warm-up: hold flags asserted until the chain holds real samples.
  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      state <= WARMUP;
      count <= '0;
    end else begin
      state <= state_d;
      count <= count_d;
    end
  end

  always_comb begin
    state_d = state;
    count_d = count;
    unique case (state)
      WARMUP: begin
        if (count == CW'(SYNC_STAGES)) begin
          state_d = READY;
        end else begin
          count_d = count + 1'b1;
        end
      end
      READY: begin
        state_d = READY;
      end
    endcase
  end

  assign sync_ready    = (state == READY);
  assign rptr_bin_sync = rptr_bin_q;
  assign wlevel        = wptr_bin - rptr_bin_q;
  assign wfull         = !sync_ready ||
                         (wlevel == PW'(DEPTH));
  assign walmost_full  = !sync_ready ||
                         (wlevel >= PW'(AFULL_LVL));

`ifdef SYNC_GRAY_CHECK_EN
  logic [PW-1:0] prev;
  logic [PW-1:0] diff;
  logic          multi_bit;
  logic          over_lvl;
  logic          err_q;

  assign diff      = prev ^ sync_out;
  assign multi_bit = (diff & (diff - 1'b1)) != '0;
  assign over_lvl  = wlevel > PW'(DEPTH);

  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      prev  <= '0;
      err_q <= 1'b0;
    end else begin
      prev <= sync_out;
      if (sync_ready && (multi_bit || over_lvl)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign gray_err = err_q;
`else
  assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_r2w_gray.sv
// Bench for sync_r2w_gray: SYNC_STAGES=2 and =4 instances, DEPTH=8.
// Reference model tracks sampled read pointers as a history queue.
module tb_sync_r2w_gray;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rptr_gray = '0;
  logic [3:0] wptr_bin = '0;

  logic [3:0] a_rbin, a_lvl, b_rbin, b_lvl;
  logic       a_full, a_afull, a_rdy, a_gerr;
  logic       b_full, b_afull, b_rdy, b_gerr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_r2w_gray #(.DEPTH(8), .SYNC_STAGES(2)) dut (
    .w_clk(clk), .rst(rst),
    .rptr_gray(rptr_gray), .wptr_bin(wptr_bin),
    .rptr_bin_sync(a_rbin), .wlevel(a_lvl),
    .wfull(a_full), .walmost_full(a_afull),
    .sync_ready(a_rdy), .gray_err(a_gerr)
  );

  sync_r2w_gray #(.DEPTH(8), .SYNC_STAGES(4)) dut4 (
    .w_clk(clk), .rst(rst),
    .rptr_gray(rptr_gray), .wptr_bin(wptr_bin),
    .rptr_bin_sync(b_rbin), .wlevel(b_lvl),
    .wfull(b_full), .walmost_full(b_afull),
    .sync_ready(b_rdy), .gray_err(b_gerr)
  );

  // Model: every edge out of reset samples rptr_gray.
  logic [3:0] hist[$];
  int edges = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      edges = 0;
    end else begin
      hist.push_back(rptr_gray);
      edges++;
    end
  end

  function automatic int gdec(logic [3:0] g);
    for (int b = 0; b < 16; b++) begin
      if (4'(b ^ (b >> 1)) == g) return b;
    end
    return 0;
  endfunction

  function automatic logic [3:0] m_rbin(int s);
    if (edges - s >= 1) return 4'(gdec(hist[edges-s-1]));
    return 4'd0;
  endfunction

  function automatic logic m_rdy(int s);
    return edges >= s + 1;
  endfunction

  function automatic logic [3:0] m_lvl(int s);
    return 4'((int'(wptr_bin) - int'(m_rbin(s)) + 16) % 16);
  endfunction

  function automatic logic m_full(int s);
    return !m_rdy(s) || m_lvl(s) == 4'd8;
  endfunction

  function automatic logic m_afull(int s);
    return !m_rdy(s) || m_lvl(s) >= 4'd6;
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    wptr_bin = '0;
    rptr_gray = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wptr_bin = 4'd5;
    rptr_gray = '0;
    tick();
    tick();
    #1;
    tests++;
    if (a_rbin !== 4'd0 || a_lvl !== 4'd5) begin
      fails++;
      $display("FAIL reset_ptr rbin=%0d lvl=%0d want 0/5",
               a_rbin, a_lvl);
    end
    tests++;
    if (a_full !== 1'b1 || a_afull !== 1'b1 ||
        a_rdy !== 1'b0 || b_rdy !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags full=%b af=%b rdy=%b/%b want 1 1 0 0",
               a_full, a_afull, a_rdy, b_rdy);
    end
    tests++;
    if (a_gerr !== 1'b0 || b_gerr !== 1'b0) begin
      fails++;
      $display("FAIL reset_gerr got %b/%b want 0", a_gerr, b_gerr);
    end
    wptr_bin = '0;
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      tests++;
      if (a_rdy !== (e >= 3) || b_rdy !== (e >= 5)) begin
        fails++;
        $display("FAIL warmup edge%0d rdy=%b/%b want %b/%b",
                 e, a_rdy, b_rdy, e >= 3, e >= 5);
      end
    end
    tests++;
    if (a_full !== 1'b0 || a_lvl !== 4'd0 || a_afull !== 1'b0) begin
      fails++;
      $display("FAIL ready_flags full=%b lvl=%0d af=%b want 0 0 0",
               a_full, a_lvl, a_afull);
    end
  endtask

  task automatic test_latency;
    do_reset();
    repeat (6) tick();
    rptr_gray = 4'b0001;
    tick();
    tick();
    tests++;
    if (a_rbin !== 4'd0) begin
      fails++;
      $display("FAIL lat2_early got %0d want 0", a_rbin);
    end
    tick();
    tests++;
    if (a_rbin !== 4'd1) begin
      fails++;
      $display("FAIL lat2 got %0d want 1", a_rbin);
    end
    tick();
    tests++;
    if (b_rbin !== 4'd0) begin
      fails++;
      $display("FAIL lat4_early got %0d want 0", b_rbin);
    end
    tick();
    tests++;
    if (b_rbin !== 4'd1) begin
      fails++;
      $display("FAIL lat4 got %0d want 1", b_rbin);
    end
  endtask

  task automatic test_thresholds;
    do_reset();
    repeat (6) tick();
    wptr_bin = 4'd6;
    #1;
    tests++;
    if (a_lvl !== 4'd6 || a_afull !== 1'b1 || a_full !== 1'b0) begin
      fails++;
      $display("FAIL thr6 lvl=%0d af=%b full=%b want 6 1 0",
               a_lvl, a_afull, a_full);
    end
    wptr_bin = 4'b1000;
    #1;
    tests++;
    if (a_lvl !== 4'd8 || a_full !== 1'b1 || a_afull !== 1'b1) begin
      fails++;
      $display("FAIL thr8 lvl=%0d full=%b af=%b want 8 1 1",
               a_lvl, a_full, a_afull);
    end
    wptr_bin = 4'd5;
    #1;
    tests++;
    if (a_lvl !== 4'd5 || a_full !== 1'b0 || a_afull !== 1'b0) begin
      fails++;
      $display("FAIL thr5 lvl=%0d full=%b af=%b want 5 0 0",
               a_lvl, a_full, a_afull);
    end
  endtask

  task automatic test_wrap;
    wptr_bin = 4'b0010;
    rptr_gray = 4'b1000;
    repeat (3) tick();
    tests++;
    if (a_rbin !== 4'd15 || a_lvl !== 4'd3 || a_full !== 1'b0) begin
      fails++;
      $display("FAIL wrap15 rbin=%0d lvl=%0d full=%b want 15 3 0",
               a_rbin, a_lvl, a_full);
    end
    rptr_gray = 4'b0000;
    repeat (3) tick();
    tests++;
    if (a_lvl !== 4'd2 || a_full !== 1'b0) begin
      fails++;
      $display("FAIL wrap0 lvl=%0d full=%b want 2 0", a_lvl, a_full);
    end
  endtask

  task automatic test_midreset;
    rptr_gray = 4'b0001;
    repeat (5) tick();
    wptr_bin = 4'd6;
    #1;
    tests++;
    if (a_lvl !== 4'd5) begin
      fails++;
      $display("FAIL mid_pre lvl=%0d want 5", a_lvl);
    end
    tick();
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (a_rbin !== 4'd0 || b_rbin !== 4'd0 || a_lvl !== 4'd6) begin
      fails++;
      $display("FAIL mid_ptr rbin=%0d/%0d lvl=%0d want 0/0 6",
               a_rbin, b_rbin, a_lvl);
    end
    tests++;
    if (a_full !== 1'b1 || a_afull !== 1'b1 || a_rdy !== 1'b0) begin
      fails++;
      $display("FAIL mid_flags full=%b af=%b rdy=%b want 1 1 0",
               a_full, a_afull, a_rdy);
    end
    #1;
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      tests++;
      if (a_rdy !== (e >= 3)) begin
        fails++;
        $display("FAIL mid_warmup edge%0d rdy=%b want %b",
                 e, a_rdy, e >= 3);
      end
    end
  endtask

  task automatic test_random;
    int rb;
    do_reset();
    rb = 0;
    for (int n = 0; n < 300; n++) begin
      tick();
      if ($urandom_range(0, 2) != 0) rb = (rb + 1) % 16;
      rptr_gray = 4'(rb ^ (rb >> 1));
      wptr_bin = 4'((int'(m_rbin(2)) + $urandom_range(0, 8)) % 16);
      #1;
      tests++;
      if (a_rbin !== m_rbin(2) || a_lvl !== m_lvl(2) ||
          a_full !== m_full(2) || a_afull !== m_afull(2) ||
          a_rdy !== m_rdy(2)) begin
        fails++;
        $display("FAIL rnd_s2 n=%0d got %0d %0d %b %b %b want %0d %0d %b %b %b",
                 n, a_rbin, a_lvl, a_full, a_afull, a_rdy, m_rbin(2),
                 m_lvl(2), m_full(2), m_afull(2), m_rdy(2));
      end
      tests++;
      if (b_rbin !== m_rbin(4) || b_lvl !== m_lvl(4) ||
          b_full !== m_full(4) || b_afull !== m_afull(4) ||
          b_rdy !== m_rdy(4)) begin
        fails++;
        $display("FAIL rnd_s4 n=%0d got %0d %0d %b %b %b want %0d %0d %b %b %b",
                 n, b_rbin, b_lvl, b_full, b_afull, b_rdy, m_rbin(4),
                 m_lvl(4), m_full(4), m_afull(4), m_rdy(4));
      end
    end
  endtask

  task automatic test_gray_check;
    logic want [6];
`ifdef SYNC_GRAY_CHECK_EN
    want = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
    want = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    do_reset();
    wptr_bin = 4'd2;
    repeat (6) tick();
    tests++;
    if (a_gerr !== want[0]) begin
      fails++;
      $display("FAIL gchk_pre got %b want %b", a_gerr, want[0]);
    end
    rptr_gray = 4'b0011;
    for (int e = 0; e <= 4; e++) begin
      tick();
      tests++;
      if (a_gerr !== want[e+1]) begin
        fails++;
        $display("FAIL gchk E0+%0d got %b want %b",
                 e, a_gerr, want[e+1]);
      end
    end
    rst = 1'b1;
    #1;
    tests++;
    if (a_gerr !== 1'b0) begin
      fails++;
      $display("FAIL gchk_rst got %b want 0", a_gerr);
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_thresholds();
    test_wrap();
    test_midreset();
    test_random();
    test_gray_check();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_r2w_gray.md
Name: sync_r2w_gray

Overview:
- Parametrised successor to the two-flop read-pointer synchroniser, for the write-clock domain of the async FIFO.
- Brings the read-side Gray pointer across through SYNC_STAGES flops, then registers a Gray-to-binary conversion.
- Derives occupancy, full and almost-full against the local binary write pointer.
- Holds the write side blocked (wfull=1) until the chain has flushed after reset.

Parameters:
DEPTH, 8, FIFO depth; power of two, >=2; ADDR_W = $clog2(DEPTH) (localparam); pointers are ADDR_W+1 bits
SYNC_STAGES, 2, synchroniser flop count; legal 2..4; elaboration error outside this range
AFULL_LVL, DEPTH-2, occupancy at or above which walmost_full asserts; legal 1..DEPTH

Ports:
w_clk  input  1  write-domain clock, rising edge
rst  input  1  asynchronous, active-high reset
rptr_gray  input  ADDR_W+1  read pointer, Gray code, asynchronous to w_clk
wptr_bin  input  ADDR_W+1  local write pointer, binary, synchronous to w_clk
rptr_bin_sync  output  ADDR_W+1  synchronised read pointer, binary, registered
wlevel  output  ADDR_W+1  occupancy seen from the write side, 0..DEPTH
wfull  output  1  FIFO full, or synchroniser not yet ready
walmost_full  output  1  wlevel >= AFULL_LVL, or not ready
sync_ready  output  1  chain flushed since reset
gray_err  output  1  sticky Gray-protocol error; tied 0 unless SYNC_GRAY_CHECK_EN is defined

Behaviour:
- Interface: one clock, w_clk. Reset is asynchronous and active-high, named rst.
- Sync chain: on each rising edge, sync[0] <= rptr_gray and sync[i] <= sync[i-1]. No logic between chain flops.
- Conversion: rptr_bin_q <= gray2bin(sync[SYNC_STAGES-1]), registered; rptr_bin_sync = rptr_bin_q.
- Latency: a value sampled at edge E0 appears on rptr_bin_sync after edge E0+SYNC_STAGES.
- Level:
  - wlevel = (wptr_bin - rptr_bin_q) mod 2^(ADDR_W+1).
  - Combinational from wptr_bin, so zero latency to write-pointer changes.
  - Pessimistic (stale read pointer only over-estimates occupancy).
- Full: wfull = !sync_ready | (wlevel == DEPTH). Equivalent to MSBs differing and lower bits equal.
- Almost full: walmost_full = !sync_ready | (wlevel >= AFULL_LVL).
- Warm-up FSM, states WARMUP and READY:
  - Reset enters WARMUP, count = 0.
  - In WARMUP, count increments every edge.
  - When count == SYNC_STAGES, the next edge moves to READY and sets sync_ready=1. sync_ready rises at the (SYNC_STAGES+1)th edge after rst deasserts.
  - READY is absorbing until reset.
  - Counter width $clog2(SYNC_STAGES+2); it does not wrap.
- Reset values:
  - All chain flops, rptr_bin_q and count are 0; state is WARMUP; sync_ready=0; gray_err=0.
  - Hence rptr_bin_sync=0, wfull=1, walmost_full=1, and wlevel = wptr_bin.
- Wrap-around: pointer arithmetic is modulo 2^(ADDR_W+1); rptr 15->0 with DEPTH=8 is legal.
- Simultaneous events: a wptr_bin change and an rptr_bin_q update in the same cycle are resolved by the combinational difference. No priority logic.
- Reset mid-operation: all registered state clears immediately (asynchronous), and the warm-up repeats.

Optional Feature:
- Macro: SYNC_GRAY_CHECK_EN.
- Defined:
  - Extra register prev <= sync[SYNC_STAGES-1].
  - Once sync_ready=1, gray_err sets when popcount(prev ^ sync[SYNC_STAGES-1]) > 1, or when the computed wlevel > DEPTH.
  - gray_err is sticky until rst.
- Undefined: no extra logic; gray_err driven constant 0.

Decomposition:
- Package sync_pkg:
  - functions gray2bin and bin2gray, parametrised by width;
  - constants SYNC_STAGES_MIN=2 and SYNC_STAGES_MAX=4;
  - enum sync_state_t {WARMUP, READY}.
- Sub-module sync_chain #(WIDTH, STAGES):
  - generic flop chain with asynchronous active-high reset;
  - instantiated once for rptr_gray;
  - reusable for the write-to-read direction.

Test Plan:
1. Reset, DEPTH=8, SYNC_STAGES=2: hold rst=1 with wptr_bin=0 -> rptr_bin_sync=0, wfull=1, walmost_full=1, sync_ready=0. Release rst -> sync_ready=1 after the 3rd edge, then wfull=0 and wlevel=0.
2. Latency: rptr_gray 0000->0001 captured at edge E0 -> rptr_bin_sync=1 after edge E0+2. Repeat with SYNC_STAGES=4 -> after edge E0+4.
3. Thresholds: rptr synced to 0 -> wptr_bin=6 gives wlevel=6 and walmost_full=1; wptr_bin=4'b1000 gives wlevel=8 and wfull=1; wptr_bin=5 gives both flags 0.
4. Wrap, wptr_bin=4'b0010: rptr_gray=gray(15)=1000 -> wlevel=3. Then gray(0)=0000 -> wlevel=2, wfull=0.
5. Mid-op reset with wlevel=5: pulse rst asynchronously between edges -> outputs reach reset values immediately, sync_ready=0, wfull=1. Warm-up repeats with 3 edges to ready.
6. Gray check: with SYNC_GRAY_CHECK_EN defined, step rptr_gray 0000->0011 after ready -> gray_err=1 at the SYNC_STAGES-th edge after capture, held until rst. Without the macro -> gray_err stays 0.
